// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the pipeline stage: occupancy state encoding and the default bubble control value.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Wide all-zero constant; each stage truncates it to its own CTRL_W.
    localparam int unsigned BUBBLE_MAX_W = 256;
    localparam logic [BUBBLE_MAX_W-1:0] BUBBLE_CTRL_DEFAULT = '0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle of one pipeline stage; slave is the stage's view, master the surroundings'.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry: enable-loaded payload+control register with asynchronous active-high reset to zero.
module pipe_entry #(
    parameter int unsigned W = 88
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with flush; macro PIPE_STAGE_SKID_EN adds a skid entry and registered in_ready,
// otherwise it is a single-entry stage with combinational in_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 24,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT)
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_skid_if.slave bus
);
    localparam int unsigned ENTRY_W = DATA_W + CTRL_W;

    pipe_state_e        r_state;
    pipe_state_e        w_next;
    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_head_en;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head_d;
    logic [ENTRY_W-1:0] w_head_q;

    assign w_out_valid = (r_state != EMPTY);
    assign w_drain     = w_out_valid & bus.out_ready;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_in_entry  = {bus.in_data, bus.in_ctrl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic               r_in_ready;
    logic               w_skid_en;
    logic [ENTRY_W-1:0] w_skid_q;

    // Registered ready: looks only at next state, so out_ready never reaches in_ready in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next != TWO);
        end
    end

    assign w_in_ready = r_in_ready;

    always_comb begin
        w_next    = r_state;
        w_head_en = 1'b0;
        w_head_d  = w_in_entry;
        w_skid_en = 1'b0;
        if (bus.flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_head_en = 1'b1;
                        w_next    = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_head_en = 1'b1;
                    end else if (w_accept) begin
                        w_skid_en = 1'b1;
                        w_next    = TWO;
                    end else if (w_drain) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        w_head_d  = w_skid_q;
                        w_head_en = 1'b1;
                        w_next    = ONE;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_skid_en),
        .i_d  (w_in_entry),
        .o_q  (w_skid_q)
    );
`else
    assign w_in_ready = bus.out_ready | ~w_out_valid;

    // In ONE an accept implies a same-cycle drain, since ready follows out_ready there.
    always_comb begin
        w_next    = r_state;
        w_head_en = 1'b0;
        w_head_d  = w_in_entry;
        if (bus.flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_head_en = 1'b1;
                        w_next    = ONE;
                    end
                end
                ONE: begin
                    if (w_accept) begin
                        w_head_en = 1'b1;
                    end else if (w_drain) begin
                        w_next = EMPTY;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end
`endif

    pipe_entry #(.W(ENTRY_W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_head_en),
        .i_d  (w_head_d),
        .o_q  (w_head_q)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head_q[ENTRY_W-1:CTRL_W];
    assign bus.out_ctrl  = w_out_valid ? w_head_q[CTRL_W-1:0] : BUBBLE_CTRL;
    assign bus.occupancy = r_state;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the reference model is an in-order FIFO of accepted payloads.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned     DW     = 64;
    localparam int unsigned     CW     = 24;
    localparam logic [CW-1:0]   BUBBLE = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    pipe_stage_skid #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .BUBBLE_CTRL (BUBBLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned n_emit = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;

    function automatic logic [CW-1:0] mkctrl(input logic [DW-1:0] d);
        return {1'b1, d[CW-2:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: at each negedge compare the presented head against the model, pop on a drain;
    // then record what the upcoming edge will accept or flush.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_data = '0;
        end else begin
            check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
`ifdef PIPE_STAGE_SKID_EN
            check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
`else
            check("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || exp_q.size() == 0));
            check("occ_max1", 64'(bus.occupancy <= 2'd1), 64'(1));
`endif
            if (bus.out_valid) begin
                last_data = bus.out_data;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h want nothing (t=%0t)", bus.out_data, $time);
                end else begin
                    check("out_data", bus.out_data, exp_q[0]);
                    check("out_ctrl", 64'(bus.out_ctrl), 64'(mkctrl(exp_q[0])));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_emit++;
                    end
                end
            end else begin
                check("bubble_ctrl", 64'(bus.out_ctrl), 64'(BUBBLE));
                check("held_data", bus.out_data, last_data);
            end
        end
        #1;
        if (rst || bus.flush) exp_q.delete();
        else if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f,
                        output logic acc);
        logic ir0;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = mkctrl(d);
        bus.out_ready = r;
        bus.flush     = f;
        ir0 = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        #1 ir0 = bus.in_ready;
        bus.out_ready = ~r;
        #1 check("in_ready_comb", 64'(bus.in_ready), 64'(ir0));
        bus.out_ready = r;
`endif
        @(negedge clk);
        acc = v && bus.in_ready && !f && !rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int unsigned i;
        int unsigned cyc;
        int unsigned e0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", bus.out_data, 64'(0));
        check("rst_ctrl", 64'(bus.out_ctrl), 64'(BUBBLE));
        check("rst_occ", 64'(bus.occupancy), 64'(0));
        check("rst_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming with one-cycle latency
        step(1'b1, 64'h1111, 1'b1, 1'b0, acc);
        check("A_valid", 64'(bus.out_valid), 64'(1));
        check("A_data1", bus.out_data, 64'h1111);
        step(1'b1, 64'h2222, 1'b1, 1'b0, acc);
        check("A_data2", bus.out_data, 64'h2222);
        step(1'b1, 64'h3333, 1'b1, 1'b0, acc);
        check("A_data3", bus.out_data, 64'h3333);
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Stall with two offers
        step(1'b1, 64'hAAAA, 1'b0, 1'b0, acc);
        step(1'b1, 64'hBBBB, 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_SKID_EN
        check("B_occ2", 64'(bus.occupancy), 64'(2));
        check("B_ready0", 64'(bus.in_ready), 64'(0));
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);
        check("B_second", bus.out_data, 64'hBBBB);
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);
`else
        check("B_no_accept", 64'(acc), 64'(0));
        check("B_occ1", 64'(bus.occupancy), 64'(1));
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);
`endif
        check("B_drained", 64'(bus.out_valid), 64'(0));

        // Flush while full, with a same-cycle offer
        step(1'b1, 64'hDDDD, 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, 64'hEEEE, 1'b0, 1'b0, acc);
        check("C_occ2", 64'(bus.occupancy), 64'(2));
`endif
        step(1'b1, 64'hCCCC, 1'b0, 1'b1, acc);
        check("C_occ0", 64'(bus.occupancy), 64'(0));
        check("C_valid0", 64'(bus.out_valid), 64'(0));
        check("C_bubble", 64'(bus.out_ctrl), 64'(BUBBLE));
        check("C_held", bus.out_data, 64'hDDDD);
        repeat (4) step(1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Drain completes in the flush cycle; the same-cycle offer is discarded
        step(1'b1, 64'hFFFF, 1'b1, 1'b0, acc);
        step(1'b1, 64'h7777, 1'b1, 1'b1, acc);
        check("F_occ0", 64'(bus.occupancy), 64'(0));
        repeat (2) step(1'b0, 64'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-cycle while holding entries
        step(1'b1, 64'h1357, 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, 64'h2468, 1'b0, 1'b0, acc);
`endif
        #2 rst = 1'b1;
        #1;
        check("D_valid0", 64'(bus.out_valid), 64'(0));
        check("D_occ0", 64'(bus.occupancy), 64'(0));
        check("D_ready1", 64'(bus.in_ready), 64'(1));
        check("D_ctrl", 64'(bus.out_ctrl), 64'(BUBBLE));
        check("D_data0", bus.out_data, 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 64'h4321, 1'b1, 1'b0, acc);
        check("D_first_valid", 64'(bus.out_valid), 64'(1));
        check("D_first_data", bus.out_data, 64'h4321);
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);

        // 1000 sequential tokens under random backpressure
        void'($urandom(1));
        e0  = n_emit;
        i   = 0;
        cyc = 0;
        while (i < 1000 && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, DW'(i), $urandom_range(0, 2) != 0, 1'b0, acc);
            if (acc) i++;
            cyc++;
        end
        check("E_all_sent", 64'(i), 64'(1000));
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            step(1'b0, 64'h0, 1'b1, 1'b0, acc);
            cyc++;
        end
        step(1'b0, 64'h0, 1'b1, 1'b0, acc);
        check("E_emitted", 64'(n_emit - e0), 64'(1000));
        check("E_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
